fp_mat_loader: RTL

FP_MAT_LOADER -- requirements
Module: fp_mat_loader

---
 rtl/fp_mat_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fp_mat_loader.sv
// Custom-instruction loader for a 5x5 matrix of 32-bit floats.
// Instructions run IDLE->EXEC->RESP under clk_en; the matrix port runs every clk edge.
module fp_mat_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  input  logic [4:0]  n,
  output logic        done,
  output logic [31:0] result,
  output logic        mat_valid,
  input  logic        mat_ack,
  input  logic [2:0]  mat_rd_row,
  input  logic [2:0]  mat_rd_col,
  output logic [31:0] mat_rd_data,
  output logic [2:0]  mat_dim
);

  localparam logic [4:0] OP_SETDIM   = 5'd0;
  localparam logic [4:0] OP_WRITE    = 5'd1;
  localparam logic [4:0] OP_COMMIT   = 5'd2;
  localparam logic [4:0] OP_READBACK = 5'd3;
  localparam logic [4:0] OP_STATUS   = 5'd4;

  localparam logic [2:0] ST_OK         = 3'd0;
  localparam logic [2:0] ST_BAD_INDEX  = 3'd1;
  localparam logic [2:0] ST_LOCKED     = 3'd2;
  localparam logic [2:0] ST_INCOMPLETE = 3'd3;
  localparam logic [2:0] ST_BAD_OP     = 3'd4;
  localparam logic [2:0] ST_BAD_DIM    = 3'd5;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] a_q;
  logic [5:0]  b_q;
  logic [4:0]  op_q;
  logic [31:0] mem [25];
  logic [24:0] bitmap;
  logic [4:0]  count;
  logic [2:0]  dim;

  logic [2:0]  row, col, new_dim;
  logic [4:0]  elem_idx, full_count, rd_idx;
  logic        in_range, dim_ok, rd_in_range, exec_fire;
  logic        do_setdim, do_write, do_commit;
  logic [31:0] exec_result;

  // Only the row/col fields of operand B carry meaning.
  logic unused_datab;
  assign unused_datab = ^datab[31:6];

  assign row         = b_q[5:3];
  assign col         = b_q[2:0];
  assign new_dim     = a_q[2:0];
  assign in_range    = (row < dim) && (col < dim);
  assign dim_ok      = (new_dim >= 3'd1) && (new_dim <= 3'd5);
  assign elem_idx    = 5'(row) * 5'd5 + 5'(col);
  assign full_count  = 5'(dim) * 5'(dim);
  assign rd_in_range = (mat_rd_row <= 3'd4) && (mat_rd_col <= 3'd4);
  assign rd_idx      = 5'(mat_rd_row) * 5'd5 + 5'(mat_rd_col);
  assign exec_fire   = clk_en && (state == EXEC);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clk_en) begin
      case (state)
        IDLE:    if (start) state_nxt = EXEC;
        EXEC:    state_nxt = RESP;
        RESP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    exec_result = 32'(ST_OK);
    do_setdim   = 1'b0;
    do_write    = 1'b0;
    do_commit   = 1'b0;
    case (op_q)
      OP_SETDIM: begin
        if (mat_valid)    exec_result = 32'(ST_LOCKED);
        else if (!dim_ok) exec_result = 32'(ST_BAD_DIM);
        else              do_setdim   = 1'b1;
      end
      OP_WRITE: begin
        if (mat_valid)     exec_result = 32'(ST_LOCKED);
        else if (!in_range) exec_result = 32'(ST_BAD_INDEX);
        else               do_write    = 1'b1;
      end
      OP_COMMIT: begin
        if (mat_valid)                exec_result = 32'(ST_LOCKED);
        else if (count != full_count) exec_result = 32'(ST_INCOMPLETE);
        else                          do_commit   = 1'b1;
      end
      OP_READBACK: begin
        if (in_range) exec_result = mem[elem_idx];
        else          exec_result = 32'(ST_BAD_INDEX);
      end
      OP_STATUS: exec_result = {23'b0, mat_valid, dim, count};
      default:   exec_result = 32'(ST_BAD_OP);
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values;
  // this is also what lets a same-edge mat_ack leave EXEC's LOCKED decision intact.
  always_ff @(posedge clk) begin
    if (!reset) begin
      done        <= 1'b0;
      result      <= '0;
      mat_valid   <= 1'b0;
      mat_dim     <= 3'd5;
      dim         <= 3'd5;
      count       <= '0;
      bitmap      <= '0;
      mat_rd_data <= '0;
    end else begin
      if (clk_en) begin
        if (state == EXEC) begin
          result <= exec_result;
          done   <= 1'b1;
        end else if (state == RESP) begin
          done   <= 1'b0;
        end
      end
      // Locked opcodes are no-ops, so an ack and an executing instruction never collide.
      if (mat_valid && mat_ack) begin
        mat_valid <= 1'b0;
        bitmap    <= '0;
        count     <= '0;
      end else if (exec_fire) begin
        if (do_setdim) begin
          dim    <= new_dim;
          bitmap <= '0;
          count  <= '0;
        end
        if (do_write) begin
          bitmap[elem_idx] <= 1'b1;
          if (!bitmap[elem_idx]) count <= count + 5'd1;
        end
        if (do_commit) begin
          mat_valid <= 1'b1;
          mat_dim   <= dim;
        end
      end
      mat_rd_data <= rd_in_range ? mem[rd_idx] : '0;
    end
  end

  // NOTE: the matrix array and operand latches have no reset; only the write is gated by it.
  always_ff @(posedge clk) begin
    if (clk_en && (state == IDLE) && start) begin
      a_q  <= dataa;
      b_q  <= datab[5:0];
      op_q <= n;
    end
    if (reset && exec_fire && do_write) mem[elem_idx] <= a_q;
  end

endmodule
